// File: rtl/gg_pipe_gate.sv
// rtl/gg_pipe_gate.sv - WIDTH-bit INPUTS-channel bitwise gate with DEPTH-stage valid-tagged pipeline
// Stall holds every stage; flush clears data and valid bits; OCC is a registered popcount of valid bits.
module gg_pipe_gate #(
  parameter  int WIDTH  = 8,
  parameter  int INPUTS = 2,
  parameter  int DEPTH  = 4,
  parameter  int OP     = 0,
  localparam int OW     = $clog2(DEPTH + 1)
) (
  input  logic                    CK,
  input  logic                    CLR,
  input  logic [INPUTS*WIDTH-1:0] I,
  input  logic                    IV,
  input  logic                    EN,
  input  logic                    FLUSH,
  output logic [WIDTH-1:0]        Z,
  output logic                    ZV,
  output logic [OW-1:0]           OCC
);

  logic [WIDTH-1:0] w_f;
  logic [WIDTH-1:0] r_d [DEPTH];
  logic [DEPTH-1:0] r_v;
  logic [OW-1:0]    r_occ;

  // BUF (and any single-channel gate) simply passes channel 0 through.
  always_comb begin
    w_f = I[WIDTH-1:0];
    for (int k = 1; k < INPUTS; k++) begin
      case (OP)
        0:       w_f = w_f & I[k*WIDTH +: WIDTH];
        1:       w_f = w_f | I[k*WIDTH +: WIDTH];
        2:       w_f = w_f ^ I[k*WIDTH +: WIDTH];
        default: w_f = w_f;
      endcase
    end
  end

  always_ff @(posedge CK or posedge CLR) begin
    if (CLR) begin
      for (int k = 0; k < DEPTH; k++) r_d[k] <= '0;
      r_v   <= '0;
      r_occ <= '0;
    end else if (FLUSH) begin
      for (int k = 0; k < DEPTH; k++) r_d[k] <= '0;
      r_v   <= '0;
      r_occ <= '0;
    end else if (EN) begin
      r_d[0] <= w_f;
      r_v[0] <= IV;
      for (int k = 1; k < DEPTH; k++) begin
        r_d[k] <= r_d[k-1];
        r_v[k] <= r_v[k-1];
      end
      // Entering and leaving valid bits cancel, so the count stays within 0..DEPTH.
      if (IV && !r_v[DEPTH-1])
        r_occ <= r_occ + OW'(1);
      else if (!IV && r_v[DEPTH-1])
        r_occ <= r_occ - OW'(1);
    end
  end

  assign Z   = r_d[DEPTH-1];
  assign ZV  = r_v[DEPTH-1];
  assign OCC = r_occ;

endmodule

// File: tb/tb_gg_pipe_gate.sv
// tb/tb_gg_pipe_gate.sv - scoreboard bench for gg_pipe_gate
// Three instances: AND (2ch, depth 4), XOR (3ch, depth 4), BUF (2ch, depth 1).
module tb_gg_pipe_gate;

  logic CK = 1'b0;
  always #5 CK = ~CK;

  logic        CLR;
  logic [15:0] a_i;
  logic        a_iv, a_en, a_fl, a_zv;
  logic [7:0]  a_z;
  logic [2:0]  a_occ;
  logic [23:0] x_i;
  logic        x_iv, x_en, x_fl, x_zv;
  logic [7:0]  x_z;
  logic [2:0]  x_occ;
  logic [15:0] b_i;
  logic        b_iv, b_en, b_fl, b_zv;
  logic [7:0]  b_z;
  logic [0:0]  b_occ;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] q_a[$];
  logic [7:0] q_x[$];
  logic [7:0] q_b[$];

  gg_pipe_gate #(.WIDTH(8), .INPUTS(2), .DEPTH(4), .OP(0)) u_and (
    .CK(CK), .CLR(CLR), .I(a_i), .IV(a_iv), .EN(a_en), .FLUSH(a_fl),
    .Z(a_z), .ZV(a_zv), .OCC(a_occ));

  gg_pipe_gate #(.WIDTH(8), .INPUTS(3), .DEPTH(4), .OP(2)) u_xor (
    .CK(CK), .CLR(CLR), .I(x_i), .IV(x_iv), .EN(x_en), .FLUSH(x_fl),
    .Z(x_z), .ZV(x_zv), .OCC(x_occ));

  gg_pipe_gate #(.WIDTH(8), .INPUTS(2), .DEPTH(1), .OP(3)) u_buf (
    .CK(CK), .CLR(CLR), .I(b_i), .IV(b_iv), .EN(b_en), .FLUSH(b_fl),
    .Z(b_z), .ZV(b_zv), .OCC(b_occ));

  task automatic tick;
    @(posedge CK);
    #1;
  endtask

  task automatic test_reset;
    a_i = 16'hFFFF; a_iv = 1'b1; a_en = 1'b1; a_fl = 1'b0;
    x_i = 24'hFFFFFF; x_iv = 1'b1; x_en = 1'b1; x_fl = 1'b0;
    b_i = 16'hFFFF; b_iv = 1'b1; b_en = 1'b1; b_fl = 1'b0;
    repeat (2) tick;
    n_tests++;
    if (a_z !== 8'h00 || a_zv !== 1'b0 || a_occ !== 3'd0) begin
      n_fail++; $display("FAIL reset_and z=%h zv=%b occ=%0d required 0/0/0", a_z, a_zv, a_occ);
    end
    n_tests++;
    if (x_z !== 8'h00 || x_zv !== 1'b0 || x_occ !== 3'd0) begin
      n_fail++; $display("FAIL reset_xor z=%h zv=%b occ=%0d required 0/0/0", x_z, x_zv, x_occ);
    end
    n_tests++;
    if (b_z !== 8'h00 || b_zv !== 1'b0 || b_occ !== 1'd0) begin
      n_fail++; $display("FAIL reset_buf z=%h zv=%b occ=%0d required 0/0/0", b_z, b_zv, b_occ);
    end
    CLR = 1'b0;
    repeat (4) tick;
    n_tests++;
    if (a_z !== 8'hFF || a_zv !== 1'b1 || a_occ !== 3'd4) begin
      n_fail++; $display("FAIL reset_fill z=%h zv=%b occ=%0d required ff/1/4", a_z, a_zv, a_occ);
    end
    #3 CLR = 1'b1;
    #1;
    n_tests++;
    if (a_z !== 8'h00 || a_zv !== 1'b0 || a_occ !== 3'd0) begin
      n_fail++; $display("FAIL reset_async z=%h zv=%b occ=%0d required 0/0/0", a_z, a_zv, a_occ);
    end
    repeat (2) tick;
    n_tests++;
    if (a_z !== 8'h00 || a_zv !== 1'b0 || a_occ !== 3'd0) begin
      n_fail++; $display("FAIL reset_held z=%h zv=%b occ=%0d required 0/0/0", a_z, a_zv, a_occ);
    end
    a_iv = 1'b0; x_iv = 1'b0; b_iv = 1'b0;
    CLR = 1'b0;
  endtask

  task automatic test_latency_and;
    logic [7:0] exp;
    a_i = {8'hF0, 8'h3C}; a_iv = 1'b1;
    q_a.push_back(8'hF0 & 8'h3C);
    for (int e = 1; e <= 5; e++) begin
      tick;
      if (e == 1) begin a_iv = 1'b0; a_i = 16'h1234; end
      n_tests++;
      if (a_zv !== (e == 4) || a_occ !== ((e <= 4) ? 3'd1 : 3'd0)) begin
        n_fail++; $display("FAIL latency_edge%0d zv=%b occ=%0d required zv=%0d occ=%0d",
                           e, a_zv, a_occ, (e == 4), (e <= 4) ? 1 : 0);
      end
      if (a_zv === 1'b1 && q_a.size() > 0) begin
        exp = q_a.pop_front();
        n_tests++;
        if (a_z !== exp) begin n_fail++; $display("FAIL latency_data z=%h required %h", a_z, exp); end
      end
    end
  endtask

  task automatic test_stream_xor;
    logic [7:0] exp;
    int seen = 0;
    int max_occ = 0;
    x_en = 1'b1;
    for (int c = 0; c < 14; c++) begin
      if (c < 8) begin
        x_i = {8'(c + 1), 8'hFF, 8'h0F}; x_iv = 1'b1;
        q_x.push_back(8'(c + 1) ^ 8'hFF ^ 8'h0F);
      end else x_iv = 1'b0;
      tick;
      if (int'(x_occ) > max_occ) max_occ = int'(x_occ);
      n_tests++;
      if (x_zv !== (c >= 3 && c <= 10) || x_occ > 3'd4) begin
        n_fail++; $display("FAIL stream_cycle%0d zv=%b occ=%0d", c, x_zv, x_occ);
      end
      if (x_zv === 1'b1) begin
        seen++;
        if (q_x.size() == 0) begin
          n_tests++; n_fail++; $display("FAIL stream_extra z=%h required none", x_z);
        end else begin
          exp = q_x.pop_front();
          n_tests++;
          if (x_z !== exp) begin n_fail++; $display("FAIL stream_data z=%h required %h", x_z, exp); end
        end
      end
    end
    n_tests++;
    if (seen != 8 || max_occ != 4) begin
      n_fail++; $display("FAIL stream_count seen=%0d max_occ=%0d required 8/4", seen, max_occ);
    end
  endtask

  task automatic test_stall;
    logic [7:0] exp;
    int seen = 0;
    a_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a_i = {8'hFF, 8'(8'h10 + k)}; a_iv = 1'b1;
      q_a.push_back(8'(8'h10 + k));
      tick;
    end
    a_en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      a_i = 16'($urandom); a_iv = 1'($urandom);
      tick;
      n_tests++;
      if (a_zv !== 1'b0 || a_occ !== 3'd3) begin
        n_fail++; $display("FAIL stall_hold%0d zv=%b occ=%0d required 0/3", k, a_zv, a_occ);
      end
    end
    a_en = 1'b1; a_iv = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick;
      if (a_zv === 1'b1) begin
        seen++;
        if (q_a.size() == 0) begin
          n_tests++; n_fail++; $display("FAIL stall_dup z=%h required none", a_z);
        end else begin
          exp = q_a.pop_front();
          n_tests++;
          if (a_z !== exp) begin n_fail++; $display("FAIL stall_data z=%h required %h", a_z, exp); end
        end
      end
    end
    n_tests++;
    if (seen != 3 || a_occ !== 3'd0) begin
      n_fail++; $display("FAIL stall_count seen=%0d occ=%0d required 3/0", seen, a_occ);
    end
  endtask

  task automatic test_flush;
    logic [7:0] exp;
    x_en = 1'b1; x_fl = 1'b0;
    for (int k = 0; k < 4; k++) begin
      x_i = {8'(8'h20 + k), 8'hFF, 8'h0F}; x_iv = 1'b1;
      q_x.push_back(8'(8'h20 + k) ^ 8'hF0);
      tick;
      if (x_zv === 1'b1 && q_x.size() > 0) begin
        exp = q_x.pop_front();
        n_tests++;
        if (x_z !== exp) begin n_fail++; $display("FAIL flush_fill z=%h required %h", x_z, exp); end
      end
    end
    n_tests++;
    if (x_occ !== 3'd4) begin n_fail++; $display("FAIL flush_full occ=%0d required 4", x_occ); end
    x_fl = 1'b1; x_iv = 1'b1; x_i = {8'hAA, 8'hFF, 8'h0F};
    tick;
    x_fl = 1'b0; x_iv = 1'b0;
    q_x.delete();
    n_tests++;
    if (x_occ !== 3'd0 || x_zv !== 1'b0 || x_z !== 8'h00) begin
      n_fail++; $display("FAIL flush_clear z=%h zv=%b occ=%0d required 0/0/0", x_z, x_zv, x_occ);
    end
    for (int k = 0; k < 6; k++) begin
      tick;
      n_tests++;
      if (x_zv !== 1'b0) begin n_fail++; $display("FAIL flush_leak z=%h zv=%b required zv=0", x_z, x_zv); end
    end
    x_i = {8'h77, 8'hFF, 8'h0F}; x_iv = 1'b1;
    q_x.push_back(8'h77 ^ 8'hF0);
    for (int e = 1; e <= 6; e++) begin
      tick;
      if (e == 1) x_iv = 1'b0;
      n_tests++;
      if (x_zv !== (e == 4)) begin
        n_fail++; $display("FAIL flush_next_edge%0d zv=%b required %0d", e, x_zv, (e == 4));
      end
      if (x_zv === 1'b1 && q_x.size() > 0) begin
        exp = q_x.pop_front();
        n_tests++;
        if (x_z !== exp) begin n_fail++; $display("FAIL flush_next_data z=%h required %h", x_z, exp); end
      end
    end
  endtask

  task automatic test_bubbles_buf;
    logic [3:0] pat = 4'b1101;
    logic [7:0] ch0;
    logic [7:0] exp;
    b_en = 1'b1; b_fl = 1'b0;
    for (int k = 0; k < 4; k++) begin
      ch0 = 8'(8'h40 + k * 8'h11);
      b_i = {8'($urandom), ch0}; b_iv = pat[k];
      if (pat[k]) q_b.push_back(ch0);
      tick;
      n_tests++;
      if (b_zv !== pat[k] || b_occ !== pat[k] || b_z !== ch0) begin
        n_fail++; $display("FAIL buf_step%0d z=%h zv=%b occ=%0d required %h/%b/%b",
                           k, b_z, b_zv, b_occ, ch0, pat[k], pat[k]);
      end
      if (b_zv === 1'b1 && q_b.size() > 0) begin
        exp = q_b.pop_front();
        n_tests++;
        if (b_z !== exp) begin n_fail++; $display("FAIL buf_data z=%h required %h", b_z, exp); end
      end
    end
    b_iv = 1'b0;
    n_tests++;
    if (q_b.size() != 0) begin n_fail++; $display("FAIL buf_left %0d required 0", q_b.size()); end
  endtask

  initial begin
    CLR = 1'b1;
    test_reset();
    test_latency_and();
    test_stream_xor();
    test_stall();
    test_flush();
    test_bubbles_buf();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gg_pipe_gate.md
# gg_pipe_gate

Parametrised successor to the single-bit delayed gate primitives: a WIDTH-bit, INPUTS-channel bitwise logic gate (AND/OR/XOR/BUF selectable) whose result travels through a DEPTH-stage registered pipeline with per-stage valid bits, stall and flush. It sits in the builtin gate library, where it is used when a gate needs cycle-accurate, clocked latency instead of an `assign #Diz` delay. An occupancy count of in-flight results is exported for the simulator's probe panel.

## Interface
- WIDTH, 8, data bits per channel and per result (1..64)
- INPUTS, 2, number of input channels reduced together (1..8)
- DEPTH, 4, pipeline stages, i.e. latency in enabled cycles (1..16)
- OP, 0, operation: 0 AND, 1 OR, 2 XOR, 3 BUF (channel 0 only, others ignored)
- OW, $clog2(DEPTH+1), width of OCC (derived, not overridden)

Ports:
- CK  input  1  clock, all state on rising edge
- CLR  input  1  reset, asynchronous, active-high
- I  input  INPUTS*WIDTH  channel k at bits [k*WIDTH +: WIDTH]
- IV  input  1  I carries a valid operand set this cycle
- EN  input  1  advance pipeline; 0 = hold every stage
- FLUSH  input  1  synchronous discard of all in-flight results
- Z  output  WIDTH  result data of last stage
- ZV  output  1  valid bit of last stage
- OCC  output  OW  number of stages currently holding a valid result

## Operation
- Combinational front end: F = bitwise OP over all INPUTS channels of I; INPUTS=1 gives F = channel 0 for every OP.
- Stage registers D[0..DEPTH-1] (WIDTH bits) and V[0..DEPTH-1].
- Per rising CK, priority FLUSH > EN > hold:
  - FLUSH=1: all V cleared to 0, all D cleared to 0, regardless of EN and IV; the operand presented that cycle is discarded.
  - EN=1: D[0]<=F, V[0]<=IV; D[k]<=D[k-1], V[k]<=V[k-1] for k>=1. Data is loaded even when IV=0 (V tags it invalid).
  - EN=0: all D, V unchanged; I/IV ignored.
- Z = D[DEPTH-1], ZV = V[DEPTH-1], both registered outputs (no combinational path from I).
- OCC = popcount of V, maintained as a registered counter: +1 if entering V[0] set and leaving V[DEPTH-1] not, -1 for the reverse, unchanged otherwise; only updates when EN=1; forced to 0 on FLUSH. Never exceeds DEPTH, never wraps.
- No backpressure input from downstream; consumer must sample Z when ZV=1 and EN was 1 on that edge.

## Timing
- CLR asserted: immediately (no clock) Z=0, ZV=0, OCC=0, all D/V=0. CLR dominates FLUSH and EN. Deassertion takes effect at the next rising CK; the first operand may be presented in the same cycle CLR falls.
- Latency: operand with IV=1 sampled at enabled edge n appears on Z with ZV=1 after edge n+DEPTH-1 (visible for the cycle following DEPTH enabled edges); edges with EN=0 add one cycle each and do not count.
- Throughput: one result per enabled cycle, no bubbles inserted.
- DEPTH=1: Z/ZV update on the same edge that samples I.
- FLUSH mid-stream: results leave with ZV=0 from the cycle after the flush edge; next valid operand needs a full DEPTH enabled edges.
- CLR mid-stream: all in-flight results lost; no partial output.

## Test plan
- Reset: WIDTH=8, DEPTH=4, assert CLR with I=8'hFF/8'hFF, IV=1, EN=1 -> Z=0, ZV=0, OCC=0 asynchronously and held while CLR=1.
- Latency/AND: OP=0, I={8'hF0,8'h3C}, IV=1 for one edge, EN=1 -> Z=8'h30 with ZV=1 exactly after 4th edge, ZV=0 the cycle after; OCC 1,1,1,1,0.
- Streaming/XOR: OP=2, INPUTS=3, operands 0x01..0x08 back-to-back on channels {x, 8'hFF, 8'h0F} -> Z sequence x^8'hF0, one per cycle, OCC saturates at 4 and never exceeds it.
- Stall: fill with 3 valid items, drop EN for 5 cycles while toggling I/IV -> Z, ZV, OCC frozen; resume -> remaining items emerge in order, no duplicate or loss.
- Flush priority: 4 items in flight, FLUSH=1, EN=1, IV=1 on one edge -> OCC=0, ZV=0 next cycle; the flush-cycle operand never appears; next operand emerges after 4 edges.
- Bubbles and BUF: OP=3, DEPTH=1, IV pattern 1,0,1,1 -> ZV 1,0,1,1 one edge later, Z = channel 0 each time, OCC tracks ZV.
